// File: rtl/uart_tx_trigger.sv
// uart_tx_trigger
//   Sends one UART 8N1 frame for each rising edge of the debounced `transmit`
//   level. The frame carries the byte on `data_in` at the trigger cycle: a
//   start bit, eight data bits LSB first, then a stop bit. A press that arrives
//   while a frame is in progress is dropped.
// Ports
//   clk       system clock, all logic on posedge
//   rst_n     asynchronous active-low reset
//   transmit  debounced button level, already synchronous to clk
//   data_in   byte to send, sampled only on the trigger cycle
//   tx        UART serial line, idle high
//   busy      high while a frame is in progress
//   done      one-cycle pulse when the stop bit completes
module uart_tx_trigger #(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int BAUD         = 9600,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       transmit,
   input  logic [7:0] data_in,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int               CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             transmit_d_q, transmit_d_d;

   logic trigger;
   logic cnt_end;

   // The edge-detect flop resets high, so a button held through reset
   // release is not seen as a fresh press.
   assign trigger = transmit & ~transmit_d_q;
   assign cnt_end = (cnt_q == CNT_MAX);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      shreg_d      = shreg_q;
      tx_d         = tx_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      // Tracked in every state so a press spanning the end of a frame
      // does not fire when busy drops.
      transmit_d_d = transmit;

      unique case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (trigger) begin
               shreg_d = data_in;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (cnt_end) begin
               cnt_d   = '0;
               tx_d    = shreg_q[0];
               idx_d   = 3'd0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_end) begin
               cnt_d = '0;
               if (idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  // shreg[0] is the bit on the line; the next one sits at [1].
                  shreg_d = shreg_q >> 1;
                  tx_d    = shreg_q[1];
                  idx_d   = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_end) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         shreg_q      <= '0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         transmit_d_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shreg_q      <= shreg_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         transmit_d_q <= transmit_d_d;
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_uart_tx_trigger.sv
module tb_uart_tx_trigger;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       transmit = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       tx, busy, done;

   int checks = 0;
   int errors = 0;

   uart_tx_trigger #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst_n(rst_n), .transmit(transmit), .data_in(data_in),
      .tx(tx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Time-based view: a frame accepted at an edge occupies the next FRAME
   // cycles; the line shows bit (elapsed/CPB) of {stop, byte, start}.
   logic [7:0] exp_q[$];
   int         remaining = 0;
   logic [9:0] cur_frame = '1;
   logic       prev_tr = 1'b1;
   logic       exp_done = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         if (remaining > 0) void'(exp_q.pop_back());
         remaining = 0;
         prev_tr   = 1'b1;
         exp_done  = 1'b0;
      end else begin
         exp_done = 1'b0;
         if (remaining > 0) begin
            remaining--;
            if (remaining == 0) exp_done = 1'b1;
         end else if (transmit && !prev_tr) begin
            remaining = FRAME;
            cur_frame = {1'b1, data_in, 1'b0};
            exp_q.push_back(data_in);
         end
         prev_tr = transmit;
      end
   end

   // ---------------- monitor ----------------
   logic cap[$];

   always @(negedge clk) begin
      logic exp_tx;
      logic [7:0] got;
      if (!rst_n) begin
         chk("reset_outputs", {29'd0, tx, busy, done}, 32'b100);
         cap.delete();
      end else begin
         exp_tx = (remaining > 0) ? cur_frame[(FRAME - remaining) / CPB] : 1'b1;
         chk("line_tx_busy_done", {29'd0, tx, busy, done},
             {29'd0, exp_tx, (remaining > 0), exp_done});
         if (busy) cap.push_back(tx);
         if (done) begin
            chk("frame_length", cap.size(), FRAME);
            if (cap.size() == FRAME) begin
               for (int b = 0; b < 8; b++) got[b] = cap[(b + 1) * CPB + CPB / 2];
               if (exp_q.size() == 0) begin
                  chk("frame_unexpected", 32'(got), 32'hFFFF_FFFF);
               end else begin
                  chk("frame_byte", 32'(got), 32'(exp_q.pop_front()));
               end
            end
            cap.delete();
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [7:0] d, input int hold);
      data_in  = d;
      transmit = 1'b1;
      step(hold);
      transmit = 1'b0;
   endtask

   initial begin
      int waited;
      // 1. reset with transmit low
      step(3);
      rst_n = 1'b1;
      step(5);

      // 2. single frame of A5
      press(8'hA5, 2);
      step(50);

      // 3. held button: one frame only, then a re-press gives another
      press(8'h96, 100);
      step(3);
      press(8'h69, 2);
      step(50);

      // 4. re-press mid-frame and change data after the trigger
      data_in  = 8'hA5;
      transmit = 1'b1;
      step(6);
      data_in  = 8'h3C;
      transmit = 1'b0;
      step(5);
      transmit = 1'b1;
      step(5);
      transmit = 1'b0;
      step(40);

      // 5. reset during bit 3 with the button held
      data_in  = 8'h5A;
      transmit = 1'b1;
      step(18);
      rst_n = 1'b0;
      #1;
      chk("async_reset_tx", {31'd0, tx}, 32'd1);
      step(2);
      rst_n = 1'b1;
      step(60);
      transmit = 1'b0;
      step(2);
      press(8'hC3, 2);

      // 6. trigger on the done cycle of that frame
      waited = 0;
      while (!done && waited < 200) begin
         step(1);
         waited++;
      end
      chk("done_wait_bounded", {31'd0, (waited < 200)}, 32'd1);
      data_in  = 8'h00;
      transmit = 1'b1;
      step(1);
      transmit = 1'b0;
      step(50);

      // randomized presses
      for (int i = 0; i < 40; i++) begin
         press(8'($urandom), $urandom_range(1, 60));
         step($urandom_range(0, 50));
      end
      step(FRAME + 10);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
